hazard_ctrl_unit: RTL and testbench

Next-generation pipeline hazard controller for the 5-stage RV32 core. It sits beside the Decode/Execute/Memory/Writeback pipeline registers.
- Provides parametrised EX-stage operand forwarding.
- Detects load-use hazards and taken-branch redirects, and generates per-stage stall/flush controls.
- Sequences multi-cycle EX operations (mul/div) with an internal state machine and latency counter.

---
 rtl/hazard_ctrl_unit.sv | 167 ++++++++++++++++
 tb/tb_hazard_ctrl_unit.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl_unit.sv
// rtl/hazard_ctrl_unit.sv - pipeline hazard controller for the 5-stage RV32 core
//
// Purpose: EX-stage operand forwarding, load-use / taken-branch hazard handling,
// and sequencing of multi-cycle EX operations (mul/div) via a RUN/MC_BUSY FSM.
//
// Optional feature macro: HAZARD_PERF_CNT_EN (adds StallCycles/FlushEvents).
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   RS1_D, RS2_D             source indices of the instruction in Decode
//   RS1_E, RS2_E, RD_E       source/destination indices in Execute
//   MemReadE                 Execute instruction is a load
//   PCSrcE                   taken branch/jump resolved in Execute
//   McStartE                 Execute instruction is a multi-cycle op (held while in EX)
//   RD_M, RegWriteM          Memory-stage destination and write enable
//   RD_W, RegWriteW          Writeback-stage destination and write enable
//   ForwardAE, ForwardBE     operand selects: 00 regfile, 10 from M, 01 from W
//   StallF, StallD, StallE   hold PC / IF-ID / ID-EX
//   FlushD, FlushE, FlushM   clear IF-ID / ID-EX / EX-MEM
//   McBusy, McDone           multi-cycle sequencer busy / result valid this cycle
//   StallCycles, FlushEvents saturating event counters (HAZARD_PERF_CNT_EN only)

module hazard_ctrl_unit #(
  parameter int ADDR_W     = 5,
  parameter int MC_LATENCY = 4,
  parameter int CNT_W      = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] RS1_D,
  input  logic [ADDR_W-1:0] RS2_D,
  input  logic [ADDR_W-1:0] RS1_E,
  input  logic [ADDR_W-1:0] RS2_E,
  input  logic [ADDR_W-1:0] RD_E,
  input  logic              MemReadE,
  input  logic              PCSrcE,
  input  logic              McStartE,
  input  logic [ADDR_W-1:0] RD_M,
  input  logic              RegWriteM,
  input  logic [ADDR_W-1:0] RD_W,
  input  logic              RegWriteW,
  output logic [1:0]        ForwardAE,
  output logic [1:0]        ForwardBE,
  output logic              StallF,
  output logic              StallD,
  output logic              StallE,
  output logic              FlushD,
  output logic              FlushE,
  output logic              FlushM,
  output logic              McBusy,
`ifdef HAZARD_PERF_CNT_EN
  output logic              McDone,
  output logic [31:0]       StallCycles,
  output logic [31:0]       FlushEvents
`else
  output logic              McDone
`endif
);

  typedef enum logic {RUN = 1'b0, MC_BUSY = 1'b1} state_e;

  // Cycle 0 of an op is spent in RUN, so the counter only covers the
  // MC_LATENCY-2 remaining stall cycles before the done cycle.
  localparam logic [CNT_W-1:0] CNT_INIT =
    (MC_LATENCY > 1) ? CNT_W'(MC_LATENCY - 2) : '0;
  localparam bit MC_MULTI = (MC_LATENCY > 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             lw_stall;

  // M-stage result is newer than W-stage, so it wins.
  function automatic logic [1:0] fwd_sel(input logic [ADDR_W-1:0] rs);
    if (RegWriteM && (RD_M != '0) && (RD_M == rs)) return 2'b10;
    else if (RegWriteW && (RD_W != '0) && (RD_W == rs)) return 2'b01;
    else return 2'b00;
  endfunction

  assign lw_stall = MemReadE && (RD_E != '0) && ((RD_E == RS1_D) || (RD_E == RS2_D));

  always_comb begin
    ForwardAE = 2'b00;
    ForwardBE = 2'b00;
    StallF    = 1'b0;
    StallD    = 1'b0;
    StallE    = 1'b0;
    FlushD    = 1'b0;
    FlushE    = 1'b0;
    FlushM    = 1'b0;
    McBusy    = 1'b0;
    McDone    = 1'b0;
    state_d   = state_q;
    cnt_d     = cnt_q;
    if (!rst) begin
      ForwardAE = fwd_sel(RS1_E);
      ForwardBE = fwd_sel(RS2_E);
      case (state_q)
        RUN: begin
          if (McStartE) begin
            if (MC_MULTI) begin
              // Freeze the front end and bubble MEM while the op occupies EX.
              StallF  = 1'b1;
              StallD  = 1'b1;
              StallE  = 1'b1;
              FlushM  = 1'b1;
              state_d = MC_BUSY;
              cnt_d   = CNT_INIT;
            end else begin
              McDone = 1'b1;
            end
          end else if (PCSrcE) begin
            // Redirect squashes the younger instructions, so any load-use stall is moot.
            FlushD = 1'b1;
            FlushE = 1'b1;
          end else if (lw_stall) begin
            StallF = 1'b1;
            StallD = 1'b1;
            FlushE = 1'b1;
          end
        end
        MC_BUSY: begin
          McBusy = 1'b1;
          if (cnt_q != '0) begin
            StallF = 1'b1;
            StallD = 1'b1;
            StallE = 1'b1;
            FlushM = 1'b1;
            cnt_d  = cnt_q - 1'b1;
          end else begin
            McDone  = 1'b1;
            state_d = RUN;
          end
        end
        default: state_d = RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt_q, flush_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (StallF && (stall_cnt_q != 32'hFFFF_FFFF)) stall_cnt_q <= stall_cnt_q + 32'd1;
      if ((FlushD || FlushE || FlushM) && (flush_cnt_q != 32'hFFFF_FFFF))
        flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign StallCycles = stall_cnt_q;
  assign FlushEvents = flush_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// tb/tb_hazard_ctrl_unit.sv - directed self-checking bench for hazard_ctrl_unit

module tb_hazard_ctrl_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] RS1_D, RS2_D, RS1_E, RS2_E, RD_E, RD_M, RD_W;
  logic       MemReadE, PCSrcE, McStartE, RegWriteM, RegWriteW;

  logic [1:0] fa4, fb4, fa1, fb1;
  logic       sf4, sd4, se4, fd4, fe4, fm4, mb4, md4;
  logic       sf1, sd1, se1, fd1, fe1, fm1, mb1, md1;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] sc4, fev4, sc1, fev1;
`endif

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  // Default-latency instance (MC_LATENCY=4).
  hazard_ctrl_unit #(.ADDR_W(5), .MC_LATENCY(4), .CNT_W(6)) dut (
    .clk(clk), .rst(rst),
    .RS1_D(RS1_D), .RS2_D(RS2_D), .RS1_E(RS1_E), .RS2_E(RS2_E), .RD_E(RD_E),
    .MemReadE(MemReadE), .PCSrcE(PCSrcE), .McStartE(McStartE),
    .RD_M(RD_M), .RegWriteM(RegWriteM), .RD_W(RD_W), .RegWriteW(RegWriteW),
    .ForwardAE(fa4), .ForwardBE(fb4),
    .StallF(sf4), .StallD(sd4), .StallE(se4),
    .FlushD(fd4), .FlushE(fe4), .FlushM(fm4),
    .McBusy(mb4),
`ifdef HAZARD_PERF_CNT_EN
    .McDone(md4), .StallCycles(sc4), .FlushEvents(fev4)
`else
    .McDone(md4)
`endif
  );

  // Single-cycle multi-cycle-op instance (MC_LATENCY=1), sharing all inputs.
  hazard_ctrl_unit #(.ADDR_W(5), .MC_LATENCY(1), .CNT_W(6)) dut1 (
    .clk(clk), .rst(rst),
    .RS1_D(RS1_D), .RS2_D(RS2_D), .RS1_E(RS1_E), .RS2_E(RS2_E), .RD_E(RD_E),
    .MemReadE(MemReadE), .PCSrcE(PCSrcE), .McStartE(McStartE),
    .RD_M(RD_M), .RegWriteM(RegWriteM), .RD_W(RD_W), .RegWriteW(RegWriteW),
    .ForwardAE(fa1), .ForwardBE(fb1),
    .StallF(sf1), .StallD(sd1), .StallE(se1),
    .FlushD(fd1), .FlushE(fe1), .FlushM(fm1),
    .McBusy(mb1),
`ifdef HAZARD_PERF_CNT_EN
    .McDone(md1), .StallCycles(sc1), .FlushEvents(fev1)
`else
    .McDone(md1)
`endif
  );

  // Control vector order: {StallF,StallD,StallE,FlushD,FlushE,FlushM,McBusy,McDone}
  wire [7:0] ctl4 = {sf4, sd4, se4, fd4, fe4, fm4, mb4, md4};
  wire [7:0] ctl1 = {sf1, sd1, se1, fd1, fe1, fm1, mb1, md1};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic clr();
    RS1_D = 0; RS2_D = 0; RS1_E = 0; RS2_E = 0; RD_E = 0; RD_M = 0; RD_W = 0;
    MemReadE = 0; PCSrcE = 0; McStartE = 0; RegWriteM = 0; RegWriteW = 0;
  endtask

  // Advance to the next cycle: inputs change just after the rising edge,
  // checks happen at the falling edge.
  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  initial begin
    clr();
    rst = 1'b1;
    #1;
    // Reset: outputs forced low even with forwarding and hazard inputs active.
    RD_M = 5; RegWriteM = 1; RS1_E = 5; MemReadE = 1; RD_E = 3; RS1_D = 3; McStartE = 1;
    sample();
    chk("rst_ctl", {24'd0, ctl4}, 32'h0);
    chk("rst_fwdA", {30'd0, fa4}, 32'h0);
    chk("rst_ctl_l1", {24'd0, ctl1}, 32'h0);
    next();
    rst = 1'b0;
    clr();

    // Multi-cycle op, McStartE held for cycles 0..3; MC_LATENCY=1 instance alongside.
    McStartE = 1;
    sample();
    chk("mc_c0", {24'd0, ctl4}, 32'h000000E4);
    chk("l1_c0", {24'd0, ctl1}, 32'h00000001);
    next();
    sample();
    chk("mc_c1", {24'd0, ctl4}, 32'h000000E6);
    chk("l1_c1", {24'd0, ctl1}, 32'h00000001);
    next();
    sample();
    chk("mc_c2", {24'd0, ctl4}, 32'h000000E6);
    next();
    sample();
    chk("mc_c3", {24'd0, ctl4}, 32'h00000003);
    next();
    McStartE = 0;
    sample();
    chk("mc_c4", {24'd0, ctl4}, 32'h00000000);
    chk("l1_idle", {24'd0, ctl1}, 32'h00000000);
    next();

    // Load-use stall on rs2.
    MemReadE = 1; RD_E = 7; RS2_D = 7;
    sample();
    chk("lw_stall", {24'd0, ctl4}, 32'h000000C8);
    next();
    // Taken branch with the same load-use condition: flush wins.
    PCSrcE = 1;
    sample();
    chk("br_over_lw", {24'd0, ctl4}, 32'h00000018);
    next();
    // Load into x0 never stalls.
    PCSrcE = 0; RD_E = 0; RS2_D = 0; RS1_D = 0;
    sample();
    chk("lw_x0", {24'd0, ctl4}, 32'h00000000);
    next();
    clr();

`ifdef HAZARD_PERF_CNT_EN
    // StallF: 3 (mc) + 1 (lw). Flush cycles: 3 (FlushM) + 1 (lw) + 1 (branch).
    sample();
    chk("perf_stall", sc4, 32'd4);
    chk("perf_flush", fev4, 32'd5);
    next();
`endif

    // Forwarding priority.
    RD_M = 5; RegWriteM = 1; RD_W = 5; RegWriteW = 1; RS1_E = 5; RS2_E = 0;
    sample();
    chk("fwdA_M", {30'd0, fa4}, 32'h2);
    chk("fwdB_none", {30'd0, fb4}, 32'h0);
    next();
    RegWriteM = 0; RS2_E = 5;
    sample();
    chk("fwdA_W", {30'd0, fa4}, 32'h1);
    chk("fwdB_W", {30'd0, fb4}, 32'h1);
    next();
    RegWriteM = 1; RD_M = 0; RD_W = 0;
    sample();
    chk("fwdA_x0", {30'd0, fa4}, 32'h0);
    next();
    RD_M = 9; RS2_E = 9; RS1_E = 4;
    sample();
    chk("fwdB_M", {30'd0, fb4}, 32'h2);
    chk("fwdA_nomatch", {30'd0, fa4}, 32'h0);
    next();
    clr();

    // Reset in cycle 2 of an op.
    McStartE = 1;
    sample();
    chk("ab_c0", {24'd0, ctl4}, 32'h000000E4);
    next();
    sample();
    chk("ab_c1", {24'd0, ctl4}, 32'h000000E6);
    next();
    rst = 1; RD_M = 3; RegWriteM = 1; RS1_E = 3;
    sample();
    chk("ab_rst_ctl", {24'd0, ctl4}, 32'h00000000);
    chk("ab_rst_fwd", {30'd0, fa4}, 32'h0);
    next();
    rst = 0; clr();
    sample();
    chk("ab_run", {24'd0, ctl4}, 32'h00000000);
    next();
    McStartE = 1;
    sample();
    chk("re_c0", {24'd0, ctl4}, 32'h000000E4);
    next();
    sample();
    chk("re_c1", {24'd0, ctl4}, 32'h000000E6);
    next();
    sample();
    chk("re_c2", {24'd0, ctl4}, 32'h000000E6);
    next();
    sample();
    chk("re_c3", {24'd0, ctl4}, 32'h00000003);
    next();
    McStartE = 0;
    sample();
    chk("re_c4", {24'd0, ctl4}, 32'h00000000);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
